// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n
//
// N-channel request arbiter with credit-based flow control. Each cycle at
// most one valid channel is granted, chosen round-robin (MODE=0) or by fixed
// priority (MODE=1, lowest index wins). The winning request is registered
// toward the shared resource. The number of in-flight requests is bounded by
// a credit counter: a grant consumes one credit and in_ready returns one.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     per-channel request valid
//   in_address   flattened addresses, channel i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   in_id        flattened IDs, channel i at [i*ID_WIDTH +: ID_WIDTH]
//   out_stall    per-channel stall (combinational), all-ones while in reset
//   in_ready     single-cycle pulse from the resource, returns one credit
//   out_valid    registered, one cycle per grant
//   out_address  registered address of the issued request
//   out_id       registered ID of the issued request
//   out_choice   registered index of the granted channel
//   out_error    sticky, set when in_ready arrives while all credits are home
module rr_arbiter_n #(
  parameter int NUM_CH          = 4,
  parameter int ADDRESS_WIDTH   = 8,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MODE            = 0,
  localparam int CH_W           = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 in_valid,
  input  logic [NUM_CH*ADDRESS_WIDTH-1:0]   in_address,
  input  logic [NUM_CH*ID_WIDTH-1:0]        in_id,
  output logic [NUM_CH-1:0]                 out_stall,
  input  logic                              in_ready,
  output logic                              out_valid,
  output logic [ADDRESS_WIDTH-1:0]          out_address,
  output logic [ID_WIDTH-1:0]               out_id,
  output logic [CH_W-1:0]                   out_choice,
  output logic                              out_error
);

  localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(MAX_OUTSTANDING);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  // State
  logic [CH_W-1:0]          ptr_reg, ptr_next;
  logic [CRED_W-1:0]        credits_reg, credits_next;
  logic                     valid_reg;
  logic [ADDRESS_WIDTH-1:0] address_reg;
  logic [ID_WIDTH-1:0]      id_reg;
  logic [CH_W-1:0]          choice_reg;
  logic                     error_reg, error_next;

  // Arbitration
  logic                     credit_avail;
  logic [NUM_CH-1:0]        upper_mask;
  logic [NUM_CH-1:0]        req_upper;
  logic [NUM_CH-1:0]        sel_req;
  logic [NUM_CH-1:0]        grant_onehot;
  logic                     grant_any;
  logic [CH_W-1:0]          grant_idx;
  logic [ADDRESS_WIDTH-1:0] grant_address;
  logic [ID_WIDTH-1:0]      grant_id;

  // Only the registered credit count gates the grant, so a credit returned
  // this cycle cannot be spent until the next one.
  assign credit_avail = (credits_reg != '0);

  // Channels at or above the pointer form the first search window of the
  // round-robin; if none of them is valid the search wraps to the full set.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign upper_mask[gi] = (CH_W'(gi) >= ptr_reg);
  end

  assign req_upper = in_valid & upper_mask;
  assign sel_req   = ((MODE == 0) && (req_upper != '0)) ? req_upper : in_valid;

  // Lowest set bit of sel_req wins; the same loop picks the index and the
  // request fields of the winner.
  always_comb begin
    logic seen;
    seen          = 1'b0;
    grant_onehot  = '0;
    grant_idx     = '0;
    grant_address = '0;
    grant_id      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_req[i] && !seen && credit_avail) begin
        grant_onehot[i] = 1'b1;
        grant_idx       = CH_W'(i);
        grant_address   = in_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        grant_id        = in_id[i*ID_WIDTH +: ID_WIDTH];
      end
      seen = seen | sel_req[i];
    end
  end

  assign grant_any = (grant_onehot != '0);

  // While in reset no request may be accepted.
  assign out_stall = reset ? (in_valid & ~grant_onehot) : {NUM_CH{1'b1}};

  // Credit, pointer and error bookkeeping
  always_comb begin
    credits_next = credits_reg;
    ptr_next     = ptr_reg;
    error_next   = error_reg;

    case ({grant_any, in_ready})
      2'b10:   credits_next = credits_reg - 1'b1;
      2'b01:   if (credits_reg != CRED_FULL) credits_next = credits_reg + 1'b1;
      default: credits_next = credits_reg;  // idle, or grant and return cancel
    endcase

    // A return with nothing outstanding is an accounting overflow.
    if (in_ready && (credits_reg == CRED_FULL)) begin
      error_next = 1'b1;
    end

    if (grant_any) begin
      ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg     <= '0;
      credits_reg <= CRED_FULL;
      valid_reg   <= 1'b0;
      address_reg <= '0;
      id_reg      <= '0;
      choice_reg  <= '0;
      error_reg   <= 1'b0;
    end else begin
      ptr_reg     <= ptr_next;
      credits_reg <= credits_next;
      error_reg   <= error_next;
      valid_reg   <= grant_any;
      // Request fields hold their last issued value between grants.
      if (grant_any) begin
        address_reg <= grant_address;
        id_reg      <= grant_id;
        choice_reg  <= grant_idx;
      end
    end
  end

  assign out_valid   = valid_reg;
  assign out_address = address_reg;
  assign out_id      = id_reg;
  assign out_choice  = choice_reg;
  assign out_error   = error_reg;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Testbench for rr_arbiter_n: one round-robin and one fixed-priority instance
// share the same stimulus and are compared against a behavioural model.
module tb_rr_arbiter_n;

  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int IW   = 4;
  localparam int MAXO = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*AW-1:0] in_address = '0;
  logic [N*IW-1:0] in_id = '0;
  logic            in_ready = 1'b0;

  logic [N-1:0]  stall_rr, stall_fp;
  logic          ov_rr, ov_fp, err_rr, err_fp;
  logic [AW-1:0] addr_rr, addr_fp;
  logic [IW-1:0] id_rr, id_fp;
  logic [1:0]    ch_rr, ch_fp;

  rr_arbiter_n #(.NUM_CH(N), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW),
                 .MAX_OUTSTANDING(MAXO), .MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_address(in_address),
    .in_id(in_id), .out_stall(stall_rr), .in_ready(in_ready),
    .out_valid(ov_rr), .out_address(addr_rr), .out_id(id_rr),
    .out_choice(ch_rr), .out_error(err_rr));

  rr_arbiter_n #(.NUM_CH(N), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW),
                 .MAX_OUTSTANDING(MAXO), .MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_address(in_address),
    .in_id(in_id), .out_stall(stall_fp), .in_ready(in_ready),
    .out_valid(ov_fp), .out_address(addr_fp), .out_id(id_fp),
    .out_choice(ch_fp), .out_error(err_fp));

  always #5 clk = ~clk;

  // Reference model state, index 0 = round-robin, 1 = fixed priority
  int            m_cred[2], m_ptr[2], m_choice[2];
  logic          m_err[2], m_ov[2];
  logic [AW-1:0] m_addr[2];
  logic [IW-1:0] m_id[2];

  // Expected stalls and sampled DUT values of the last cycle
  logic [N-1:0]  e_stall[2], a_stall[2];
  logic          a_ov[2], a_err[2];
  logic [AW-1:0] a_addr[2];
  logic [IW-1:0] a_id[2];
  int            a_choice[2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cred[m] = MAXO; m_ptr[m] = 0; m_choice[m] = 0;
      m_err[m] = 1'b0; m_ov[m] = 1'b0; m_addr[m] = '0; m_id[m] = '0;
    end
  endtask

  // Winner by the arbitration rules, -1 when nothing can be granted.
  function automatic int pick(input int m, input logic [N-1:0] v);
    if (m_cred[m] == 0) return -1;
    for (int o = 0; o < N; o++) begin
      int c;
      c = (m == 0) ? (m_ptr[m] + o) % N : o;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] rand_addr();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'($urandom);
    return r;
  endfunction

  function automatic logic [N*IW-1:0] rand_id();
    logic [N*IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = IW'($urandom);
    return r;
  endfunction

  // One clock cycle: drive, sample stalls mid-cycle, advance the model at
  // the edge, then sample registered outputs just after it.
  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N*IW-1:0] ids, input logic rdy);
    int w[2];
    in_valid = v; in_address = a; in_id = ids; in_ready = rdy;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      w[m] = pick(m, v);
      e_stall[m] = v;
      if (w[m] >= 0) e_stall[m][w[m]] = 1'b0;
    end
    a_stall[0] = stall_rr; a_stall[1] = stall_fp;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rdy && m_cred[m] == MAXO) m_err[m] = 1'b1;
      if (w[m] >= 0) begin
        m_ov[m] = 1'b1; m_addr[m] = a[w[m]*AW +: AW]; m_id[m] = ids[w[m]*IW +: IW];
        m_choice[m] = w[m];
        if (m == 0) m_ptr[m] = (w[m] + 1) % N;
      end else begin
        m_ov[m] = 1'b0;
      end
      if (w[m] >= 0 && !rdy) m_cred[m] = m_cred[m] - 1;
      else if (w[m] < 0 && rdy && m_cred[m] < MAXO) m_cred[m] = m_cred[m] + 1;
    end
    #1;
    a_ov[0] = ov_rr;   a_ov[1] = ov_fp;
    a_err[0] = err_rr; a_err[1] = err_fp;
    a_addr[0] = addr_rr; a_addr[1] = addr_fp;
    a_id[0] = id_rr;   a_id[1] = id_fp;
    a_choice[0] = int'(ch_rr); a_choice[1] = int'(ch_fp);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #3;
    n_checks++; if (ov_rr !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ov_rr); else n_pass++;
    n_checks++; if (addr_rr !== 8'h00) $display("FAIL reset_address: got %h expected 00", addr_rr); else n_pass++;
    n_checks++; if (id_rr !== 4'h0) $display("FAIL reset_id: got %h expected 0", id_rr); else n_pass++;
    n_checks++; if (ch_rr !== 2'd0) $display("FAIL reset_choice: got %0d expected 0", ch_rr); else n_pass++;
    n_checks++; if (err_rr !== 1'b0) $display("FAIL reset_error: got %b expected 0", err_rr); else n_pass++;
    n_checks++; if (stall_rr !== 4'hF) $display("FAIL reset_stall_rr: got %b expected 1111", stall_rr); else n_pass++;
    n_checks++; if (stall_fp !== 4'hF) $display("FAIL reset_stall_fp: got %b expected 1111", stall_fp); else n_pass++;
    #8 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    cycle(4'b0100, 32'h005A_0000, 16'h0300, 1'b0);
    $display("single: stall=%b valid=%b addr=%h id=%h choice=%0d", a_stall[0], a_ov[0], a_addr[0], a_id[0], a_choice[0]);
    n_checks++; if (a_stall[0][2] !== 1'b0) $display("FAIL single_stall: got %b expected 0", a_stall[0][2]); else n_pass++;
    n_checks++; if (a_ov[0] !== 1'b1) $display("FAIL single_valid: got %b expected 1", a_ov[0]); else n_pass++;
    n_checks++; if (a_addr[0] !== 8'h5A) $display("FAIL single_address: got %h expected 5a", a_addr[0]); else n_pass++;
    n_checks++; if (a_id[0] !== 4'h3) $display("FAIL single_id: got %h expected 3", a_id[0]); else n_pass++;
    n_checks++; if (a_choice[0] !== 2) $display("FAIL single_choice: got %0d expected 2", a_choice[0]); else n_pass++;
    // Pointer now at 3: with everyone valid channel 3 wins round-robin
    cycle(4'b1111, rand_addr(), rand_id(), 1'b1);
    $display("single_ptr: rr choice=%0d fp choice=%0d", a_choice[0], a_choice[1]);
    n_checks++; if (a_choice[0] !== 3) $display("FAIL single_ptr: got %0d expected 3", a_choice[0]); else n_pass++;
    n_checks++; if (a_choice[1] !== 0) $display("FAIL single_fp_choice: got %0d expected 0", a_choice[1]); else n_pass++;
  endtask

  task automatic test_fairness();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    int stall_cnt[N] = '{0, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      cycle(4'b1111, rand_addr(), rand_id(), 1'b1);
      $display("fairness %0d: choice=%0d stall=%b", k, a_choice[0], a_stall[0]);
      n_checks++; if (a_choice[0] !== seq[k]) $display("FAIL fair_choice_%0d: got %0d expected %0d", k, a_choice[0], seq[k]); else n_pass++;
      n_checks++; if (a_ov[0] !== 1'b1) $display("FAIL fair_valid_%0d: got %b expected 1", k, a_ov[0]); else n_pass++;
      if (k < 4) for (int i = 0; i < N; i++) stall_cnt[i] += int'(a_stall[0][i]);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (stall_cnt[i] != 3) $display("FAIL fair_stall_count_ch%0d: got %0d expected 3", i, stall_cnt[i]); else n_pass++;
    end
  endtask

  task automatic test_fixed_priority();
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1010, rand_addr(), rand_id(), 1'b1);
      $display("fixed %0d: choice=%0d stall=%b", k, a_choice[1], a_stall[1]);
      n_checks++; if (a_choice[1] !== 1) $display("FAIL fixed_choice_%0d: got %0d expected 1", k, a_choice[1]); else n_pass++;
      n_checks++; if (a_stall[1][3] !== 1'b1) $display("FAIL fixed_stall3_%0d: got %b expected 1", k, a_stall[1][3]); else n_pass++;
    end
    cycle(4'b1000, rand_addr(), rand_id(), 1'b1);
    $display("fixed drop: choice=%0d stall=%b", a_choice[1], a_stall[1]);
    n_checks++; if (a_choice[1] !== 3) $display("FAIL fixed_drop_choice: got %0d expected 3", a_choice[1]); else n_pass++;
    n_checks++; if (a_stall[1][3] !== 1'b0) $display("FAIL fixed_drop_stall: got %b expected 0", a_stall[1][3]); else n_pass++;
  endtask

  task automatic test_credit_exhaustion();
    logic [N*AW-1:0] a;
    logic [N*IW-1:0] ids;
    logic exp_st[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic rdy_seq[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    a = rand_addr(); ids = rand_id();
    cycle(4'b0000, a, ids, 1'b1);  // top credits back up to full
    for (int k = 0; k < 8; k++) begin
      cycle(4'b0001, a, ids, rdy_seq[k]);
      $display("credit %0d: rdy=%b stall=%b valid=%b", k, rdy_seq[k], a_stall[0][0], a_ov[0]);
      for (int m = 0; m < 2; m++) begin
        n_checks++; if (a_stall[m][0] !== exp_st[k]) $display("FAIL credit_stall_%0d_%0d: got %b expected %b", m, k, a_stall[m][0], exp_st[k]); else n_pass++;
        n_checks++; if (a_ov[m] !== !exp_st[k]) $display("FAIL credit_valid_%0d_%0d: got %b expected %b", m, k, a_ov[m], !exp_st[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    logic exp_st[3] = '{1'b0, 1'b0, 1'b1};
    logic rdy_seq[3] = '{1'b1, 1'b0, 1'b0};
    cycle(4'b0000, '0, '0, 1'b1);
    cycle(4'b0000, '0, '0, 1'b1);
    n_checks++; if (a_err[0] !== 1'b0) $display("FAIL ovf_no_error: got %b expected 0", a_err[0]); else n_pass++;
    cycle(4'b0000, '0, '0, 1'b1);
    $display("overflow: err_rr=%b err_fp=%b", a_err[0], a_err[1]);
    n_checks++; if (a_err[0] !== 1'b1) $display("FAIL ovf_error_rr: got %b expected 1", a_err[0]); else n_pass++;
    n_checks++; if (a_err[1] !== 1'b1) $display("FAIL ovf_error_fp: got %b expected 1", a_err[1]); else n_pass++;
    cycle(4'b0000, '0, '0, 1'b0);
    cycle(4'b0000, '0, '0, 1'b0);
    n_checks++; if (a_err[0] !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", a_err[0]); else n_pass++;
    // Credits stayed at full: exactly two grants before stalling
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0001, rand_addr(), rand_id(), 1'b0);
      $display("ovf credits %0d: stall=%b", k, a_stall[0][0]);
      n_checks++; if (a_stall[0][0] !== exp_st[k]) $display("FAIL ovf_credit_%0d: got %b expected %b", k, a_stall[0][0], exp_st[k]); else n_pass++;
    end
    // One credit back, then grant and return together leaves it at one
    cycle(4'b0000, '0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0001, rand_addr(), rand_id(), rdy_seq[k]);
      $display("simul %0d: rdy=%b stall=%b", k, rdy_seq[k], a_stall[0][0]);
      n_checks++; if (a_stall[0][0] !== exp_st[k]) $display("FAIL simul_stall_%0d: got %b expected %b", k, a_stall[0][0], exp_st[k]); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    cycle(4'b0000, '0, '0, 1'b1);
    cycle(4'b0000, '0, '0, 1'b1);
    cycle(4'b0001, rand_addr(), rand_id(), 1'b0);
    n_checks++; if (a_ov[0] !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", a_ov[0]); else n_pass++;
    in_valid = 4'b1111;
    #2 reset = 1'b0;
    #1;
    $display("async reset: valid=%b addr=%h id=%h choice=%0d err=%b stall=%b", ov_rr, addr_rr, id_rr, ch_rr, err_rr, stall_rr);
    n_checks++; if (ov_rr !== 1'b0 || ov_fp !== 1'b0) $display("FAIL areset_valid: got %b%b expected 00", ov_rr, ov_fp); else n_pass++;
    n_checks++; if (addr_rr !== 8'h00) $display("FAIL areset_address: got %h expected 00", addr_rr); else n_pass++;
    n_checks++; if (id_rr !== 4'h0) $display("FAIL areset_id: got %h expected 0", id_rr); else n_pass++;
    n_checks++; if (ch_rr !== 2'd0) $display("FAIL areset_choice: got %0d expected 0", ch_rr); else n_pass++;
    n_checks++; if (err_rr !== 1'b0) $display("FAIL areset_error: got %b expected 0", err_rr); else n_pass++;
    n_checks++; if (stall_rr !== 4'hF) $display("FAIL areset_stall: got %b expected 1111", stall_rr); else n_pass++;
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    for (int k = 0; k <= MAXO; k++) begin
      cycle(4'b0001, rand_addr(), rand_id(), 1'b0);
      $display("post reset %0d: stall=%b valid=%b", k, a_stall[0][0], a_ov[0]);
      n_checks++; if (a_ov[0] !== (k < MAXO)) $display("FAIL areset_grant_%0d: got %b expected %b", k, a_ov[0], (k < MAXO)); else n_pass++;
    end
    // Two answers for the two new grants, then the forgotten one overflows
    cycle(4'b0000, '0, '0, 1'b1);
    cycle(4'b0000, '0, '0, 1'b1);
    n_checks++; if (a_err[0] !== 1'b0) $display("FAIL areset_late_noerr: got %b expected 0", a_err[0]); else n_pass++;
    cycle(4'b0000, '0, '0, 1'b1);
    n_checks++; if (a_err[0] !== 1'b1) $display("FAIL areset_late_err: got %b expected 1", a_err[0]); else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0]    v, held;
    logic [N*AW-1:0] a;
    logic [N*IW-1:0] ids;
    logic            rdy;
    v = '0; held = '0; a = '0; ids = '0;
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < N; c++) begin
        if (!held[c]) begin
          v[c] = ($urandom_range(0, 99) < 60);
          a[c*AW +: AW] = AW'($urandom);
          ids[c*IW +: IW] = IW'($urandom);
        end
      end
      rdy = ($urandom_range(0, 99) < 40);
      cycle(v, a, ids, rdy);
      held = v & (e_stall[0] | e_stall[1]);
      if (t % 50 == 0) $display("random %0d: v=%b rdy=%b rr_choice=%0d fp_choice=%0d", t, v, rdy, a_choice[0], a_choice[1]);
      for (int m = 0; m < 2; m++) begin
        n_checks++; if (a_stall[m] !== e_stall[m]) $display("FAIL rand_stall_%0d_t%0d: got %b expected %b", m, t, a_stall[m], e_stall[m]); else n_pass++;
        n_checks++; if (a_ov[m] !== m_ov[m]) $display("FAIL rand_valid_%0d_t%0d: got %b expected %b", m, t, a_ov[m], m_ov[m]); else n_pass++;
        n_checks++; if (a_addr[m] !== m_addr[m]) $display("FAIL rand_address_%0d_t%0d: got %h expected %h", m, t, a_addr[m], m_addr[m]); else n_pass++;
        n_checks++; if (a_id[m] !== m_id[m]) $display("FAIL rand_id_%0d_t%0d: got %h expected %h", m, t, a_id[m], m_id[m]); else n_pass++;
        n_checks++; if (a_choice[m] !== m_choice[m]) $display("FAIL rand_choice_%0d_t%0d: got %0d expected %0d", m, t, a_choice[m], m_choice[m]); else n_pass++;
        n_checks++; if (a_err[m] !== m_err[m]) $display("FAIL rand_error_%0d_t%0d: got %b expected %b", m, t, a_err[m], m_err[m]); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_fixed_priority();
    test_credit_exhaustion();
    test_overflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-channel request arbiter with credit-based flow control: the successor to the two-channel arbiter between the pipelines and the shared resource. It accepts address/ID requests from NUM_CH pipelines on a valid/stall handshake and selects one per cycle in round-robin or fixed-priority mode. It registers the winning request toward the shared resource. The number of in-flight requests is bounded by MAX_OUTSTANDING credits, which the resource returns through in_ready.

## Interface
- NUM_CH, 4: number of requesting channels, 2..16.
- ADDRESS_WIDTH, 8: request address width.
- ID_WIDTH, 4: request ID width.
- MAX_OUTSTANDING, 2: maximum requests issued but not yet answered, 1..15.
- MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- CH_W: localparam, clog2(NUM_CH), minimum 1.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  NUM_CH  per-channel request valid.
- in_address  input  NUM_CH*ADDRESS_WIDTH  flattened addresses; channel i occupies [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- in_id  input  NUM_CH*ID_WIDTH  flattened IDs, packed the same way.
- out_stall  output  NUM_CH  per-channel stall; the request is not accepted this cycle.
- in_ready  input  1  single-cycle pulse from the resource; returns one credit.
- out_valid  output  1  registered; request issued to the resource.
- out_address  output  ADDRESS_WIDTH  registered address of the issued request.
- out_id  output  ID_WIDTH  registered ID of the issued request.
- out_choice  output  CH_W  registered index of the granted channel.
- out_error  output  1  sticky; set when in_ready arrives while credits == MAX_OUTSTANDING.

## Operation
- Handshake: a request on channel i is accepted in the cycle where in_valid[i] is high and out_stall[i] is low. While out_stall[i] is high, the channel holds valid, address and ID stable.
- out_stall is combinational: out_stall[i] = in_valid[i] & ~grant[i]. out_stall[i] is 0 when in_valid[i] is 0.
- Grant: at most one grant per cycle, and only when credits > 0. When credits == 0, every valid channel is stalled.
- Round-robin: the search starts at pointer ptr and wraps modulo NUM_CH. The first valid channel wins. After a grant to channel k, ptr = (k+1) mod NUM_CH. ptr is unchanged when there is no grant.
- Fixed priority: the lowest valid index wins. ptr is not used.
- Credit counter width is clog2(MAX_OUTSTANDING+1).
  - Grant only: credits−1.
  - in_ready only: credits+1, saturating at MAX_OUTSTANDING. A saturating in_ready sets out_error.
  - Grant and in_ready in the same cycle: credits unchanged.
  - in_ready with credits == 0 and a pending request: the credit is usable only from the next cycle. There is no combinational path from in_ready to the grant.
- On a grant to channel k, the next edge registers out_valid=1, out_address=in_address[k], out_id=in_id[k] and out_choice=k. Without a grant, out_valid=0 and the other output registers hold their values.
- MODE is static. Changing it at runtime is undefined.

## Timing
- Reset asserted (reset=0), applied asynchronously:
  - out_valid=0, out_address=0, out_id=0, out_choice=0, out_error=0.
  - credits=MAX_OUTSTANDING, ptr=0.
  - out_stall is forced to all-ones while reset is low.
- Reset deasserted mid-transaction: in-flight requests are forgotten and credits are restored to full. Responses that arrive later are counted as overflow.
- Latency: a request accepted in cycle T appears with out_valid=1 in cycle T+1.
- out_valid is high for exactly one cycle per grant. Back-to-back grants give continuous out_valid.
- Sustained throughput: one request per cycle while credits stay above 0.
- A channel stalled in cycle T sees a fresh arbitration decision in T+1.

## Test plan
- Single request: NUM_CH=4, channel 2 asserts address 0x5A and id 0x3 with credits full.
  - out_stall[2]=0 in that cycle.
  - Next cycle: out_valid=1, out_address=0x5A, out_id=0x3, out_choice=2. ptr becomes 3.
- Round-robin fairness: all four channels are held valid and in_ready is pulsed every cycle.
  - out_choice sequence is 0,1,2,3,0,1.
  - Each channel is stalled in exactly 3 of every 4 cycles.
- Fixed priority (MODE=1): channels 1 and 3 are valid continuously, with in_ready returning every cycle.
  - Channel 1 wins every cycle; channel 3 stays stalled until channel 1 drops valid.
- Credit exhaustion: MAX_OUTSTANDING=2, no in_ready, channel 0 valid.
  - Two grants are issued in consecutive cycles, then out_stall[0]=1 persists.
  - After one in_ready pulse, exactly one more grant is issued, one cycle after the pulse.
- Overflow and simultaneity:
  - in_ready pulsed with credits full: out_error=1 and stays set; credits unchanged.
  - Grant and in_ready in the same cycle: credit count unchanged, checked by an identical stall pattern afterward.
- Asynchronous reset mid-operation: assert reset between clock edges with 1 credit outstanding and out_valid=1.
  - Outputs clear immediately, without waiting for an edge, and out_stall is all-ones.
  - After release, MAX_OUTSTANDING grants are possible before any in_ready.
